iic_slave_rw: RTL and testbench

- I2C target (slave) with register-style addressing; the responder to the team's IIC master transaction sequencer.
- Samples raw SCL/SDA and detects START, repeated START and STOP.
- Matches the 7-bit device address, receives P_ADDRWIDTH/8 address bytes MSB first, then either emits write bytes to a local register file or fetches and shifts out read bytes.
- The address auto-increments per data byte. SDA is open-drain, driven through an output-enable.

---
 rtl/iic_slave_rw_if.sv | 27 ++
 rtl/iic_slave_rw.sv | 203 ++++++++++++++++++++
 tb/tb_iic_slave_rw.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/iic_slave_rw_if.sv
// I2C target bus bundle: raw pins, own address and the local register-file port.
//   slave  : view taken by iic_slave_rw
//   master : view taken by whatever drives the pins and serves read data
interface iic_slave_rw_if #(
  parameter int unsigned P_ADDRWIDTH = 16
);
  logic [6:0]             I_device;   // own 7-bit device address
  logic                   I_scl;      // raw SCL pin
  logic                   I_sda;      // raw SDA pin
  logic                   O_sda_oe;   // 1 = pull SDA low
  logic [P_ADDRWIDTH-1:0] O_addr;     // current register address
  logic [7:0]             O_wrdata;   // received write byte
  logic                   O_wrvalid;  // write strobe
  logic                   O_rdreq;    // read request strobe
  logic [7:0]             I_rddata;   // read byte, one cycle after O_rdreq
  logic                   O_busy;     // addressed

  modport slave (
    input  I_device, I_scl, I_sda, I_rddata,
    output O_sda_oe, O_addr, O_wrdata, O_wrvalid, O_rdreq, O_busy
  );

  modport master (
    output I_device, I_scl, I_sda, I_rddata,
    input  O_sda_oe, O_addr, O_wrdata, O_wrvalid, O_rdreq, O_busy
  );
endinterface

// File: rtl/iic_slave_rw.sv
// I2C target with register addressing: device byte, P_ADDRWIDTH/8 address
// bytes MSB first, then auto-incrementing write or read data bytes.
//   I_clk, I_rst : system clock (>=16x SCL), synchronous active-high reset
//   bus          : pins, own address, register-file port (iic_slave_rw_if.slave)
module iic_slave_rw #(
  parameter int unsigned P_ADDRWIDTH = 16
) (
  input  logic                 I_clk,
  input  logic                 I_rst,
  iic_slave_rw_if.slave        bus
);
  localparam int unsigned AW = P_ADDRWIDTH;
  localparam int unsigned NB = P_ADDRWIDTH / 8;
  localparam int unsigned CW = $clog2(NB + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DEV, S_DEV_ACK, S_ADDR, S_WR, S_RD
  } state_t;

  // Pin synchronisers plus one delay stage for edge/condition detection.
  logic scl_m_q, scl_s_q, scl_d_q;
  logic sda_m_q, sda_s_q, sda_d_q;

  state_t          state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      sr_q, sr_d;
  logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
  logic            rw_q, rw_d;
  logic [7:0]      tx_q, tx_d;
  logic            oe_q, oe_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      wrdata_q, wrdata_d;
  logic            wrvalid_q, wrvalid_d;
  logic            rdreq_q, rdreq_d;
  logic            rd_pend_q, rd_pend_d;
  logic            busy_q, busy_d;

  logic       rise, fall, start_cond, stop_cond;
  logic [7:0] rx_byte;

  assign rise       =  scl_s_q & ~scl_d_q;
  assign fall       = ~scl_s_q &  scl_d_q;
  assign start_cond =  scl_s_q &  scl_d_q & ~sda_s_q &  sda_d_q;
  assign stop_cond  =  scl_s_q &  scl_d_q &  sda_s_q & ~sda_d_q;
  assign rx_byte    = {sr_q[6:0], sda_s_q};

  // State and datapath registers.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      scl_m_q    <= 1'b1;
      scl_s_q    <= 1'b1;
      scl_d_q    <= 1'b1;
      sda_m_q    <= 1'b1;
      sda_s_q    <= 1'b1;
      sda_d_q    <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      byte_cnt_q <= '0;
      rw_q       <= 1'b0;
      tx_q       <= '0;
      oe_q       <= 1'b0;
      addr_q     <= '0;
      wrdata_q   <= '0;
      wrvalid_q  <= 1'b0;
      rdreq_q    <= 1'b0;
      rd_pend_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      scl_m_q    <= bus.I_scl;
      scl_s_q    <= scl_m_q;
      scl_d_q    <= scl_s_q;
      sda_m_q    <= bus.I_sda;
      sda_s_q    <= sda_m_q;
      sda_d_q    <= sda_s_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      byte_cnt_q <= byte_cnt_d;
      rw_q       <= rw_d;
      tx_q       <= tx_d;
      oe_q       <= oe_d;
      addr_q     <= addr_d;
      wrdata_q   <= wrdata_d;
      wrvalid_q  <= wrvalid_d;
      rdreq_q    <= rdreq_d;
      rd_pend_q  <= rd_pend_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic. bit_cnt counts SCL rises in a byte: 0..7 data,
  // 8 = ACK slot open, 9 = ACK bit sampled and waiting for its falling edge.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    byte_cnt_d = byte_cnt_q;
    rw_d       = rw_q;
    tx_d       = tx_q;
    oe_d       = oe_q;
    addr_d     = addr_q;
    wrdata_d   = wrdata_q;
    wrvalid_d  = 1'b0;
    rdreq_d    = 1'b0;
    rd_pend_d  = rdreq_q;
    busy_d     = busy_q;

    if (wrvalid_q) addr_d = addr_q + AW'(1);

    if (start_cond) begin
      state_d   = S_DEV;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      rd_pend_d = 1'b0;
    end else if (stop_cond) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      rd_pend_d = 1'b0;
      busy_d    = 1'b0;
    end else if (state_q != S_IDLE) begin
      // Read byte arrives one cycle after the request; put its MSB on the bus.
      if (rd_pend_q && state_q == S_RD) begin
        tx_d = bus.I_rddata;
        oe_d = ~bus.I_rddata[7];
      end

      if (rise) begin
        if (bit_cnt_q < 4'd8) begin
          sr_d      = rx_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            unique case (state_q)
              S_DEV: begin
                if (rx_byte[7:1] == bus.I_device) begin
                  state_d = S_DEV_ACK;
                  rw_d    = rx_byte[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                end
              end
              S_ADDR: begin
                addr_d     = (addr_q << 8) | AW'(rx_byte);
                byte_cnt_d = byte_cnt_q - CW'(1);
              end
              S_WR: begin
                wrdata_d  = rx_byte;
                wrvalid_d = 1'b1;
              end
              default: ;
            endcase
          end
        end else if (bit_cnt_q == 4'd8) begin
          bit_cnt_d = 4'd9;
          // Master NACK ends a read burst without advancing the address.
          if (state_q == S_RD && sda_s_q) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            busy_d    = 1'b0;
          end
        end
      end else if (fall) begin
        if (bit_cnt_q == 4'd8) begin
          // ACK slot: we acknowledge, except when reading (master acknowledges).
          oe_d = (state_q != S_RD);
        end else if (bit_cnt_q == 4'd9) begin
          bit_cnt_d = '0;
          oe_d      = 1'b0;
          unique case (state_q)
            S_DEV_ACK: begin
              if (rw_q) begin
                state_d = S_RD;
                rdreq_d = 1'b1;
              end else begin
                state_d    = S_ADDR;
                byte_cnt_d = CW'(NB);
              end
            end
            S_ADDR: if (byte_cnt_q == '0) state_d = S_WR;
            S_RD: begin
              addr_d  = addr_q + AW'(1);
              rdreq_d = 1'b1;
            end
            default: ;
          endcase
        end else if (state_q == S_RD && bit_cnt_q != 4'd0) begin
          tx_d = tx_q << 1;
          oe_d = ~tx_q[6];
        end
      end
    end
  end

  assign bus.O_sda_oe  = oe_q;
  assign bus.O_addr    = addr_q;
  assign bus.O_wrdata  = wrdata_q;
  assign bus.O_wrvalid = wrvalid_q;
  assign bus.O_rdreq   = rdreq_q;
  assign bus.O_busy    = busy_q;
endmodule

// File: tb/tb_iic_slave_rw.sv
// Directed bench for iic_slave_rw: bit-banged I2C master, scoreboard queues
// for expected write strobes and read requests, checked by a forked monitor.
module tb_iic_slave_rw;
  localparam int unsigned QT = 10;  // clocks per quarter SCL period

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic sda_line;

  int n_checks = 0;
  int n_errors = 0;
  int wr_extra = 0;
  int rd_extra = 0;
  logic oe_ever = 1'b0;
  logic busy_ever = 1'b0;

  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];

  iic_slave_rw_if #(.P_ADDRWIDTH(16)) bus ();

  assign sda_line     = m_sda & ~bus.O_sda_oe;
  assign bus.I_scl    = m_scl;
  assign bus.I_sda    = sda_line;
  assign bus.I_device = 7'h50;
  assign bus.I_rddata = bus.O_addr[7:0];

  iic_slave_rw #(.P_ADDRWIDTH(16)) dut (
    .I_clk (clk),
    .I_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic q();
    repeat (QT) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; q();
    m_scl = 1'b1; q();
    m_sda = 1'b0; q();
    m_scl = 1'b0; q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; q();
    m_scl = 1'b1; q();
    m_sda = 1'b1; q(); q();
  endtask

  task automatic send_bit(input logic b, output logic r);
    m_sda = b;    q();
    m_scl = 1'b1; q();
    r = sda_line; q();
    m_scl = 1'b0; q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) send_bit(b[i], r);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, r);
      d[i] = r;
    end
    send_bit(mack, r);
  endtask

  // Scoreboard monitor: pops expectations as the DUT strobes.
  task automatic monitor();
    logic prev_oe = 1'b0;
    wr_t  ew;
    logic [15:0] er;
    forever begin
      @(negedge clk);
      if (bus.O_sda_oe) oe_ever = 1'b1;
      if (bus.O_busy) busy_ever = 1'b1;
      if (bus.O_sda_oe !== prev_oe) chk("oe_change_scl_high", 32'(m_scl), 32'd0);
      prev_oe = bus.O_sda_oe;
      if (bus.O_wrvalid) begin
        if (exp_wr.size() == 0) wr_extra++;
        else begin
          ew = exp_wr.pop_front();
          chk("wr_addr", 32'(bus.O_addr), 32'(ew.addr));
          chk("wr_data", 32'(bus.O_wrdata), 32'(ew.data));
        end
      end
      if (bus.O_rdreq) begin
        if (exp_rd.size() == 0) rd_extra++;
        else begin
          er = exp_rd.pop_front();
          chk("rd_addr", 32'(bus.O_addr), 32'(er));
        end
      end
    end
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_wr_pending"}, 32'(exp_wr.size()), 32'd0);
    chk({tag, "_rd_pending"}, 32'(exp_rd.size()), 32'd0);
    chk({tag, "_wr_extra"},   32'(wr_extra), 32'd0);
    chk({tag, "_rd_extra"},   32'(rd_extra), 32'd0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    wr_t        w;

    fork
      monitor();
    join_none

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    chk("rst_oe",      32'(bus.O_sda_oe),  32'd0);
    chk("rst_addr",    32'(bus.O_addr),    32'd0);
    chk("rst_wrdata",  32'(bus.O_wrdata),  32'd0);
    chk("rst_strobes", 32'({bus.O_wrvalid, bus.O_rdreq, bus.O_busy}), 32'd0);
    rst = 1'b0;
    q();

    // Write burst 0x1234 <- AB, CD
    w.addr = 16'h1234; w.data = 8'hAB; exp_wr.push_back(w);
    w.addr = 16'h1235; w.data = 8'hCD; exp_wr.push_back(w);
    i2c_start();
    write_byte(8'hA0, ack); chk("wr_ack_dev",  32'(ack), 32'd0);
    write_byte(8'h12, ack); chk("wr_ack_a1",   32'(ack), 32'd0);
    write_byte(8'h34, ack); chk("wr_ack_a0",   32'(ack), 32'd0);
    write_byte(8'hAB, ack); chk("wr_ack_d0",   32'(ack), 32'd0);
    write_byte(8'hCD, ack); chk("wr_ack_d1",   32'(ack), 32'd0);
    chk("wr_busy_before_stop", 32'(bus.O_busy), 32'd1);
    i2c_stop();
    chk("wr_busy_after_stop", 32'(bus.O_busy), 32'd0);
    check_drained("write");

    // Random read: set address 0x0010, repeated START, read two bytes
    exp_rd.push_back(16'h0010);
    exp_rd.push_back(16'h0011);
    i2c_start();
    write_byte(8'hA0, ack); chk("rd_ack_dev_w", 32'(ack), 32'd0);
    write_byte(8'h00, ack); chk("rd_ack_a1",    32'(ack), 32'd0);
    write_byte(8'h10, ack); chk("rd_ack_a0",    32'(ack), 32'd0);
    i2c_start();
    write_byte(8'hA1, ack); chk("rd_ack_dev_r", 32'(ack), 32'd0);
    read_byte(1'b0, d);     chk("rd_byte0", 32'(d), 32'h10);
    read_byte(1'b1, d);     chk("rd_byte1", 32'(d), 32'h11);
    chk("rd_busy_after_nack", 32'(bus.O_busy), 32'd0);
    chk("rd_addr_no_inc",     32'(bus.O_addr), 32'h0011);
    i2c_stop();
    check_drained("read");

    // Address mismatch
    oe_ever = 1'b0;
    busy_ever = 1'b0;
    i2c_start();
    write_byte(8'hA2, ack); chk("mm_nack_dev", 32'(ack), 32'd1);
    write_byte(8'h00, ack);
    write_byte(8'h20, ack);
    write_byte(8'h55, ack); chk("mm_nack_last", 32'(ack), 32'd1);
    i2c_stop();
    chk("mm_oe_never",   32'(oe_ever),   32'd0);
    chk("mm_busy_never", 32'(busy_ever), 32'd0);
    check_drained("mismatch");

    // Address wrap at 0xFFFF
    w.addr = 16'hFFFF; w.data = 8'h01; exp_wr.push_back(w);
    w.addr = 16'h0000; w.data = 8'h02; exp_wr.push_back(w);
    w.addr = 16'h0001; w.data = 8'h03; exp_wr.push_back(w);
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'hFF, ack);
    write_byte(8'hFF, ack);
    write_byte(8'h01, ack);
    write_byte(8'h02, ack);
    write_byte(8'h03, ack); chk("wrap_ack_last", 32'(ack), 32'd0);
    i2c_stop();
    chk("wrap_addr_final", 32'(bus.O_addr), 32'h0002);
    check_drained("wrap");

    // STOP in the middle of a write data byte
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h00, ack);
    write_byte(8'h20, ack);
    for (int i = 0; i < 4; i++) send_bit(1'b1, ack);
    i2c_stop();
    chk("abort_busy", 32'(bus.O_busy), 32'd0);
    check_drained("abort");

    // Reset while driving a 0 read bit (MSB of 0x10)
    exp_rd.push_back(16'h0010);
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h00, ack);
    write_byte(8'h10, ack);
    i2c_start();
    write_byte(8'hA1, ack);
    chk("rr_oe_bit7", 32'(bus.O_sda_oe), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rr_oe",      32'(bus.O_sda_oe), 32'd0);
    chk("rr_addr",    32'(bus.O_addr),   32'd0);
    chk("rr_wrdata",  32'(bus.O_wrdata), 32'd0);
    chk("rr_strobes", 32'({bus.O_wrvalid, bus.O_rdreq, bus.O_busy}), 32'd0);
    rst = 1'b0;
    q();
    i2c_stop();
    chk("rr_busy_idle", 32'(bus.O_busy), 32'd0);
    check_drained("rst_read");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
